// File: rtl/rs_encode_stream_in_ctrl.sv
// Input controller of the streaming RS encoder: takes a block-count request, forwards it to
// the output controller, then streams first/last-tagged data lines through one register stage.
module rs_encode_stream_in_ctrl #(
  parameter int unsigned DATA_W          = 256,
  parameter int unsigned LINES_PER_BLOCK = 7,
  parameter int unsigned BLOCK_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   src_req_val,
  input  logic [BLOCK_CNT_W-1:0] src_req_num_blocks,
  output logic                   src_req_rdy,
  output logic                   in_ctrl_out_ctrl_val,
  output logic [BLOCK_CNT_W-1:0] in_ctrl_out_ctrl_num_blocks,
  input  logic                   out_ctrl_in_ctrl_rdy,
  input  logic                   src_data_val,
  input  logic [DATA_W-1:0]      src_data,
  output logic                   src_data_rdy,
  output logic                   in_ctrl_line_encode_val,
  output logic [DATA_W-1:0]      in_ctrl_line_encode_data,
  output logic                   in_ctrl_line_encode_first,
  output logic                   in_ctrl_line_encode_last,
  input  logic                   line_encode_in_ctrl_rdy,
  output logic                   busy
);

  localparam int unsigned LINE_CNT_W = $clog2(LINES_PER_BLOCK + 1);
  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(LINES_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    META   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                 state;
  logic [LINE_CNT_W-1:0]  line_cnt;
  logic [BLOCK_CNT_W-1:0] block_cnt;

  logic req_fire;
  logic meta_fire;
  logic data_fire;
  logic drain;
  logic line_first;
  logic line_last;
  logic blk_last;

  // The stage can take a new line whenever it is empty or draining this cycle.
  assign src_data_rdy = (state == STREAM) & (~in_ctrl_line_encode_val | line_encode_in_ctrl_rdy);

  assign req_fire   = src_req_val & src_req_rdy;
  assign meta_fire  = in_ctrl_out_ctrl_val & out_ctrl_in_ctrl_rdy;
  assign data_fire  = src_data_val & src_data_rdy;
  assign drain      = in_ctrl_line_encode_val & line_encode_in_ctrl_rdy;
  assign line_first = (line_cnt == '0);
  assign line_last  = (line_cnt == LAST_LINE);
  assign blk_last   = (block_cnt == in_ctrl_out_ctrl_num_blocks - BLOCK_CNT_W'(1));

  assign busy = (state != IDLE) | in_ctrl_line_encode_val;

  // Request / metadata / streaming control with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                       <= IDLE;
      src_req_rdy                 <= 1'b0;
      in_ctrl_out_ctrl_val        <= 1'b0;
      in_ctrl_out_ctrl_num_blocks <= '0;
      line_cnt                    <= '0;
      block_cnt                   <= '0;
    end else begin
      case (state)
        IDLE: begin
          src_req_rdy <= 1'b1;
          // A zero-block request is consumed without producing any metadata.
          if (req_fire && (src_req_num_blocks != '0)) begin
            state                       <= META;
            src_req_rdy                 <= 1'b0;
            in_ctrl_out_ctrl_val        <= 1'b1;
            in_ctrl_out_ctrl_num_blocks <= src_req_num_blocks;
            line_cnt                    <= '0;
            block_cnt                   <= '0;
          end
        end
        META: begin
          if (meta_fire) begin
            state                <= STREAM;
            in_ctrl_out_ctrl_val <= 1'b0;
          end
        end
        STREAM: begin
          if (data_fire) begin
            if (line_last) begin
              line_cnt  <= '0;
              block_cnt <= block_cnt + BLOCK_CNT_W'(1);
              if (blk_last) begin
                state       <= IDLE;
                src_req_rdy <= 1'b1;
              end
            end else begin
              line_cnt <= line_cnt + LINE_CNT_W'(1);
            end
          end
        end
        default: begin
          state                <= IDLE;
          src_req_rdy          <= 1'b0;
          in_ctrl_out_ctrl_val <= 1'b0;
        end
      endcase
    end
  end

  // Single output stage; a simultaneous drain and load keeps one line per cycle flowing.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ctrl_line_encode_val   <= 1'b0;
      in_ctrl_line_encode_data  <= '0;
      in_ctrl_line_encode_first <= 1'b0;
      in_ctrl_line_encode_last  <= 1'b0;
    end else if (data_fire) begin
      in_ctrl_line_encode_val   <= 1'b1;
      in_ctrl_line_encode_data  <= src_data;
      in_ctrl_line_encode_first <= line_first;
      in_ctrl_line_encode_last  <= line_last;
    end else if (drain) begin
      in_ctrl_line_encode_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_encode_stream_in_ctrl.sv
// Scoreboard bench for rs_encode_stream_in_ctrl: directed scenarios plus randomized traffic,
// with expected lines/metadata derived from request position and checked by a separate monitor.
`timescale 1ns/1ps
module tb_rs_encode_stream_in_ctrl;

  localparam int DATA_W = 256;
  localparam int LPB    = 7;
  localparam int BCW    = 16;

  localparam int M_STALL  = 0;
  localparam int M_ALWAYS = 1;
  localparam int M_TOGGLE = 2;
  localparam int M_RANDOM = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              src_req_val = 1'b0;
  logic [BCW-1:0]    src_req_num_blocks = '0;
  logic              src_req_rdy;
  logic              in_ctrl_out_ctrl_val;
  logic [BCW-1:0]    in_ctrl_out_ctrl_num_blocks;
  logic              out_ctrl_in_ctrl_rdy = 1'b1;
  logic              src_data_val = 1'b0;
  logic [DATA_W-1:0] src_data = '0;
  logic              src_data_rdy;
  logic              in_ctrl_line_encode_val;
  logic [DATA_W-1:0] in_ctrl_line_encode_data;
  logic              in_ctrl_line_encode_first;
  logic              in_ctrl_line_encode_last;
  logic              line_encode_in_ctrl_rdy = 1'b1;
  logic              busy;

  rs_encode_stream_in_ctrl #(
    .DATA_W(DATA_W),
    .LINES_PER_BLOCK(LPB),
    .BLOCK_CNT_W(BCW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_req_val(src_req_val),
    .src_req_num_blocks(src_req_num_blocks),
    .src_req_rdy(src_req_rdy),
    .in_ctrl_out_ctrl_val(in_ctrl_out_ctrl_val),
    .in_ctrl_out_ctrl_num_blocks(in_ctrl_out_ctrl_num_blocks),
    .out_ctrl_in_ctrl_rdy(out_ctrl_in_ctrl_rdy),
    .src_data_val(src_data_val),
    .src_data(src_data),
    .src_data_rdy(src_data_rdy),
    .in_ctrl_line_encode_val(in_ctrl_line_encode_val),
    .in_ctrl_line_encode_data(in_ctrl_line_encode_data),
    .in_ctrl_line_encode_first(in_ctrl_line_encode_first),
    .in_ctrl_line_encode_last(in_ctrl_line_encode_last),
    .line_encode_in_ctrl_rdy(line_encode_in_ctrl_rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              first;
    logic              last;
  } line_t;

  line_t          line_q[$];
  logic [BCW-1:0] meta_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int enc_mode = M_ALWAYS;
  int out_mode = M_ALWAYS;

  // Reference model: idle / awaiting-metadata / lines-left-to-accept, plus line index in request.
  bit             m_meta    = 1'b0;
  bit             m_req_rdy = 1'b0;
  int             m_left    = 0;
  int             m_idx     = 0;
  logic [BCW-1:0] m_num     = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired, got no handshake, expected completion (t=%0t)", name, $time);
  endtask

  // Ready generators for encoder and output controller, updated just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (enc_mode)
        M_STALL:  line_encode_in_ctrl_rdy = 1'b0;
        M_ALWAYS: line_encode_in_ctrl_rdy = 1'b1;
        M_TOGGLE: line_encode_in_ctrl_rdy = ~line_encode_in_ctrl_rdy;
        default:  line_encode_in_ctrl_rdy = 1'($urandom_range(1));
      endcase
      case (out_mode)
        M_STALL:  out_ctrl_in_ctrl_rdy = 1'b0;
        M_ALWAYS: out_ctrl_in_ctrl_rdy = 1'b1;
        default:  out_ctrl_in_ctrl_rdy = 1'($urandom_range(1));
      endcase
    end
  end

  // Model: check handshake readies against model state, then advance the model for this edge.
  always @(negedge clk) begin
    line_t e;
    if (!rst) begin
      check1("src_req_rdy", src_req_rdy, m_req_rdy);
      check1("meta_val", in_ctrl_out_ctrl_val, m_meta);
      check1("src_data_rdy", src_data_rdy,
             (m_left > 0) && (!in_ctrl_line_encode_val || line_encode_in_ctrl_rdy));
    end
    #1;
    if (rst) begin
      line_q.delete();
      meta_q.delete();
      m_meta    = 1'b0;
      m_left    = 0;
      m_idx     = 0;
      m_req_rdy = 1'b0;
    end else begin
      if (src_req_val && src_req_rdy && (src_req_num_blocks != '0)) begin
        m_meta = 1'b1;
        m_num  = src_req_num_blocks;
        meta_q.push_back(src_req_num_blocks);
      end else if (in_ctrl_out_ctrl_val && out_ctrl_in_ctrl_rdy) begin
        m_meta = 1'b0;
        m_left = int'(m_num) * LPB;
        m_idx  = 0;
      end
      if (src_data_val && src_data_rdy) begin
        e.data  = src_data;
        e.first = ((m_idx % LPB) == 0);
        e.last  = ((m_idx % LPB) == LPB - 1);
        line_q.push_back(e);
        m_idx++;
        m_left--;
      end
      m_req_rdy = !m_meta && (m_left == 0);
    end
  end

  // Monitor: output-stage occupancy, busy, stall stability, and popped-line / metadata compares.
  bit    stalled = 1'b0;
  line_t held;
  always @(negedge clk) begin
    line_t  got;
    line_t  exp;
    logic [BCW-1:0] exp_num;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      check1("line_val", in_ctrl_line_encode_val, line_q.size() != 0);
      check1("busy", busy, m_meta || (m_left > 0) || (line_q.size() != 0));
      got.data  = in_ctrl_line_encode_data;
      got.first = in_ctrl_line_encode_first;
      got.last  = in_ctrl_line_encode_last;
      if (stalled) begin
        check1("hold_val", in_ctrl_line_encode_val, 1'b1);
        checkw("hold_data", got.data, held.data);
        check1("hold_first", got.first, held.first);
        check1("hold_last", got.last, held.last);
      end
      stalled = in_ctrl_line_encode_val && !line_encode_in_ctrl_rdy;
      held    = got;
      if (in_ctrl_line_encode_val && line_encode_in_ctrl_rdy) begin
        if (line_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL line_extra: got line %0h, expected none", got.data);
        end else begin
          exp = line_q.pop_front();
          checkw("line_data", got.data, exp.data);
          check1("line_first", got.first, exp.first);
          check1("line_last", got.last, exp.last);
        end
      end
      if (in_ctrl_out_ctrl_val && out_ctrl_in_ctrl_rdy) begin
        if (meta_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL meta_extra: got num_blocks %0d, expected none", in_ctrl_out_ctrl_num_blocks);
        end else begin
          exp_num = meta_q.pop_front();
          check_int("meta_num_blocks", int'(in_ctrl_out_ctrl_num_blocks), int'(exp_num));
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] r;
    for (int k = 0; k < DATA_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic send_req(input int n);
    src_req_val        = 1'b1;
    src_req_num_blocks = BCW'(n);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (src_req_rdy) begin
        @(posedge clk);
        #1;
        src_req_val = 1'b0;
        return;
      end
    end
    src_req_val = 1'b0;
    fail_timeout("send_req");
  endtask

  task automatic send_lines(input int n, input int pct);
    int waited;
    waited = 0;
    for (int i = 0; i < n; i++) begin
      src_data = rand_line();
      forever begin
        src_data_val = (int'($urandom_range(99)) < pct);
        @(negedge clk);
        if (src_data_val && src_data_rdy) begin
          @(posedge clk);
          #1;
          break;
        end
        @(posedge clk);
        #1;
        waited++;
        if (waited > 5000) begin
          src_data_val = 1'b0;
          fail_timeout("send_lines");
          return;
        end
      end
    end
    src_data_val = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_timeout("wait_idle");
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_req_rdy"}, src_req_rdy, 1'b0);
    check1({tag, "_meta_val"}, in_ctrl_out_ctrl_val, 1'b0);
    check_int({tag, "_meta_num"}, int'(in_ctrl_out_ctrl_num_blocks), 0);
    check1({tag, "_data_rdy"}, src_data_rdy, 1'b0);
    check1({tag, "_line_val"}, in_ctrl_line_encode_val, 1'b0);
    checkw({tag, "_line_data"}, in_ctrl_line_encode_data, '0);
    check1({tag, "_line_first"}, in_ctrl_line_encode_first, 1'b0);
    check1({tag, "_line_last"}, in_ctrl_line_encode_last, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    int cnt;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Two blocks, everything ready: one metadata cycle then 14 lines back-to-back.
    send_req(2);
    t0 = cyc;
    send_lines(2 * LPB, 100);
    check_int("t1_latency", cyc - t0, 2 * LPB + 1);
    wait_idle();

    // Encoder ready toggling every cycle.
    enc_mode = M_TOGGLE;
    send_req(1);
    send_lines(LPB, 100);
    enc_mode = M_ALWAYS;
    wait_idle();

    // Output controller holds off metadata for five cycles while data is offered.
    out_mode = M_STALL;
    fork
      begin
        send_req(1);
        send_lines(LPB, 100);
      end
      begin
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 5; i++) begin
          @(negedge clk);
          if (in_ctrl_out_ctrl_val && !out_ctrl_in_ctrl_rdy) cnt++;
        end
        out_mode = M_ALWAYS;
      end
    join
    wait_idle();

    // Zero-block request is consumed without metadata or data movement.
    send_req(0);
    src_data     = rand_line();
    src_data_val = 1'b1;
    @(negedge clk);
    check1("t4_meta_val", in_ctrl_out_ctrl_val, 1'b0);
    check1("t4_busy", busy, 1'b0);
    check1("t4_req_rdy", src_req_rdy, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    src_data_val = 1'b0;

    // Reset in the middle of block 1 discards the request and the buffered line.
    send_req(2);
    send_lines(LPB + 3, 100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid");
    rst = 1'b0;
    send_req(1);
    send_lines(LPB, 100);
    wait_idle();

    // Back-to-back requests with the encoder stalled on the last line of the first.
    send_req(1);
    send_lines(LPB, 100);
    enc_mode = M_STALL;
    fork
      begin
        send_req(3);
        send_lines(3 * LPB, 100);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        enc_mode = M_ALWAYS;
      end
    join
    wait_idle();

    // Randomized traffic, requests issued without waiting for the previous one to drain.
    enc_mode = M_RANDOM;
    out_mode = M_RANDOM;
    for (int r = 0; r < 25; r++) begin
      n = int'($urandom_range(3));
      send_req(n);
      send_lines(n * LPB, int'($urandom_range(30, 100)));
    end
    enc_mode = M_ALWAYS;
    out_mode = M_ALWAYS;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check_int("end_lines_pending", line_q.size(), 0);
    check_int("end_meta_pending", meta_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
